ms_pic165x_boot_ctrl: RTL and testbench
=======================================

Name: ms_pic165x_boot_ctrl

Overview:
Boot/load controller for the ms_pic165x core. It receives a framed program image as a byte stream from a UART RX front end and writes 12-bit words into the shared instruction RAM. It holds the core in reset while loading and releases it once the image checksum verifies. After that it hands the RAM read port to the core's PC fetch path, and it returns to load mode on a reload request.

Parameters:
AW, 10, instruction address width (matches core pc width)
SYNC_BYTE, 8'hA5, frame start marker
TIMEOUT_CYC, 65535, max idle cycles between bytes inside a frame

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-high
rx_data  input  8  received byte
rx_valid  input  1  byte available
rx_ready  output  1  byte accepted when rx_valid & rx_ready
boot_req  input  1  single-cycle reload request
pc  input  AW  core fetch address
instr  output  12  instruction to core
core_rst_n  output  1  core reset, active-low
mem_addr  output  AW  instruction RAM address
mem_wdata  output  12  RAM write data
mem_we  output  1  RAM write strobe
mem_rdata  input  12  RAM read data (asynchronous read)
busy  output  1  frame in progress
done  output  1  image loaded, core running
err  output  1  load failed
err_code  output  2  1=bad count, 2=checksum, 3=timeout

Behaviour:
- Reset values: state=SYNC, core_rst_n=0, mem_we=0, busy=0, done=0, err=0, err_code=0, rx_ready=1, instr=12'h000.
- Frame format: SYNC_BYTE, CNT_LO, CNT_HI, then N words of 2 bytes each (low 8 bits first, then a byte whose bits[3:0] are instr[11:8] and whose bits[7:4] are ignored), then CSUM.
- Checksum rule: the 8-bit sum of CNT_LO, CNT_HI, all data bytes and CSUM must equal 0.
- States: SYNC, CNT_LO, CNT_HI, D_LO, D_HI, CSUM, RUN, ERROR. A transition happens only on an accepted byte, except for timeout and boot_req.
- SYNC: a byte equal to SYNC_BYTE moves to CNT_LO; any other byte is discarded.
- CNT_HI: N = {CNT_HI, CNT_LO}. If N==0 or N>2**AW, go to ERROR with err_code=1. Otherwise clear the word index and go to D_LO.
- D_LO: latch the low byte.
- D_HI: on accept, mem_we=1 for exactly one cycle (the cycle after accept), with mem_addr=index and mem_wdata={byte[3:0],lo}. Then index+1. When index reaches N, go to CSUM, else go to D_LO.
- CSUM: if the running sum is 0, go to RUN: core_rst_n=1 and done=1 from the next cycle. Otherwise go to ERROR with err_code=2.
- busy=1 in CNT_LO through CSUM.
- Timeout: an idle counter runs in CNT_LO through CSUM and clears on every accept. When it reaches TIMEOUT_CYC, go to ERROR with err_code=3.
- RAM written during a failed load is not restored. The core stays in reset, so the partial image is never executed.
- RUN: rx_ready=0, mem_addr=pc, instr=mem_rdata combinationally (zero-latency fetch, as the core requires). mem_we=0.
- In every non-RUN state: instr=12'h000 (NOP), mem_addr=write index, core_rst_n=0.
- ERROR: err=1, core stays in reset, rx_ready=1. SYNC_BYTE restarts the load (go to CNT_LO, clear err/err_code); other bytes are discarded.
- boot_req in RUN: the next cycle has core_rst_n=0, done=0, state=SYNC. boot_req in CNT_LO through CSUM aborts the frame and returns to SYNC, with no error. boot_req in ERROR goes to SYNC and clears err.
- rst in any state, including mid-write, gives reset values on the next edge. A pending mem_we is dropped.
- Index and counter widths are AW+1 bits, so N=2**AW is representable. No wrap of the write address is allowed.

Decomposition:
- Shared package ms_pic165x_pkg: state enum, err_code constants (ERR_NONE, ERR_COUNT, ERR_CSUM, ERR_TIMEOUT), NOP constant 12'h000.
- One sub-module: ms_boot_frame_fsm (byte parser, checksum, timeout, write generation).
- The top handles port muxing (mem_addr/instr), core_rst_n and status outputs.

Test Plan:
- Valid image: A5 03 00, words 0x0C01 / 0x025 / 0xA00, matching CSUM. Required: three mem_we pulses at addr 0,1,2 with data 12'hC01, 12'h025, 12'hA00; then core_rst_n=1, done=1, instr tracks mem_rdata at pc.
- Garbage before sync (bytes 00 FF 5A, then the valid frame): the garbage is ignored and the load result is identical to the valid-image case.
- Bad checksum (valid frame with CSUM+1): err=1, err_code=2, core_rst_n stays 0, instr=12'h000.
- Count check: N=0 gives err_code=1; N=1025 with AW=10 gives err_code=1; N=1024 is accepted and the last write is at addr 1023.
- Timeout with TIMEOUT_CYC=100: stall after D_LO. Required: ERROR with err_code=3 exactly 100 cycles after the last accept.
- Reload: boot_req while in RUN gives core_rst_n=0 the next cycle and state SYNC. A second valid frame then reloads and restarts the core. Asserting rst mid-D_HI gives reset values and no mem_we.

Source files
------------

// File: rtl/ms_pic165x_pkg.sv
// Shared definitions for the ms_pic165x boot/load controller.
// Holds the loader state encoding, the error-code values reported on err_code,
// the NOP instruction fed to the core while it is held in reset, and a helper
// that says whether a state is inside a frame (CNT_LO .. CSUM).
package ms_pic165x_pkg;

    typedef enum logic [2:0] {
        ST_SYNC,
        ST_CNT_LO,
        ST_CNT_HI,
        ST_D_LO,
        ST_D_HI,
        ST_CSUM,
        ST_RUN,
        ST_ERROR
    } boot_state_t;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_COUNT   = 2'd1;
    localparam logic [1:0] ERR_CSUM    = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT = 2'd3;

    localparam logic [11:0] NOP = 12'h000;

    function automatic logic in_frame(input boot_state_t s);
        return (s == ST_CNT_LO) || (s == ST_CNT_HI) || (s == ST_D_LO) ||
               (s == ST_D_HI)   || (s == ST_CSUM);
    endfunction

endpackage

// File: rtl/ms_boot_frame_fsm.sv
// Frame parser for the boot loader.
// Consumes the byte stream (SYNC, CNT_LO, CNT_HI, N x {LO, HI}, CSUM), keeps the
// running 8-bit checksum, watches the inter-byte idle time and produces one
// registered RAM write per received word.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   rx_data/rx_valid  incoming byte; accepted whenever the loader is not running
//   boot_req          abort / reload request
//   state             current loader state
//   err_code          reason for the last failed load (0 when none)
//   wr_en/wr_addr/wr_data  one-cycle RAM write, issued the cycle after a HI byte
module ms_boot_frame_fsm
    import ms_pic165x_pkg::*;
#(
    parameter int         AW          = 10,
    parameter logic [7:0] SYNC_BYTE   = 8'hA5,
    parameter int         TIMEOUT_CYC = 65535
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [7:0]    rx_data,
    input  logic          rx_valid,
    input  logic          boot_req,
    output boot_state_t   state,
    output logic [1:0]    err_code,
    output logic          wr_en,
    output logic [AW-1:0] wr_addr,
    output logic [11:0]   wr_data
);

    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    // The counter holds TIMEOUT_CYC-1 on the last idle cycle that is still legal.
    localparam logic [TW-1:0] IDLE_LAST = TW'(TIMEOUT_CYC - 1);
    localparam logic [16:0]   MAX_WORDS = 17'(2 ** AW);

    boot_state_t   state_reg, state_next;
    logic [7:0]    cnt_lo_reg, cnt_lo_next;
    logic [AW:0]   n_reg, n_next;
    logic [AW:0]   idx_reg, idx_next;
    logic [7:0]    lo_reg, lo_next;
    logic [7:0]    sum_reg, sum_next;
    logic [TW-1:0] idle_reg, idle_next;
    logic [1:0]    err_code_reg, err_code_next;
    logic          we_reg, we_next;
    logic [AW-1:0] addr_reg, addr_next;
    logic [11:0]   wdata_reg, wdata_next;

    logic          accept;
    logic          framing;
    logic [7:0]    sum_add;
    logic [AW:0]   idx_inc;
    logic [15:0]   count;

    assign accept  = rx_valid && (state_reg != ST_RUN);
    assign framing = in_frame(state_reg);
    assign sum_add = sum_reg + rx_data;
    assign idx_inc = idx_reg + 1'b1;
    assign count   = {rx_data, cnt_lo_reg};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= ST_SYNC;
            cnt_lo_reg   <= '0;
            n_reg        <= '0;
            idx_reg      <= '0;
            lo_reg       <= '0;
            sum_reg      <= '0;
            idle_reg     <= '0;
            err_code_reg <= ERR_NONE;
            we_reg       <= 1'b0;
            addr_reg     <= '0;
            wdata_reg    <= '0;
        end else begin
            state_reg    <= state_next;
            cnt_lo_reg   <= cnt_lo_next;
            n_reg        <= n_next;
            idx_reg      <= idx_next;
            lo_reg       <= lo_next;
            sum_reg      <= sum_next;
            idle_reg     <= idle_next;
            err_code_reg <= err_code_next;
            we_reg       <= we_next;
            addr_reg     <= addr_next;
            wdata_reg    <= wdata_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        cnt_lo_next   = cnt_lo_reg;
        n_next        = n_reg;
        idx_next      = idx_reg;
        lo_next       = lo_reg;
        sum_next      = sum_reg;
        idle_next     = '0;
        err_code_next = err_code_reg;
        we_next       = 1'b0;
        addr_next     = addr_reg;
        wdata_next    = wdata_reg;

        if (framing) begin
            idle_next = accept ? '0 : idle_reg + 1'b1;
            if (accept) begin
                sum_next = sum_add;
            end
        end

        case (state_reg)
            ST_SYNC, ST_ERROR: begin
                if (accept && rx_data == SYNC_BYTE) begin
                    state_next    = ST_CNT_LO;
                    sum_next      = '0;
                    err_code_next = ERR_NONE;
                end
            end
            ST_CNT_LO: begin
                if (accept) begin
                    cnt_lo_next = rx_data;
                    state_next  = ST_CNT_HI;
                end
            end
            ST_CNT_HI: begin
                if (accept) begin
                    if (count == 16'd0 || {1'b0, count} > MAX_WORDS) begin
                        state_next    = ST_ERROR;
                        err_code_next = ERR_COUNT;
                    end else begin
                        n_next     = count[AW:0];
                        idx_next   = '0;
                        state_next = ST_D_LO;
                    end
                end
            end
            ST_D_LO: begin
                if (accept) begin
                    lo_next    = rx_data;
                    state_next = ST_D_HI;
                end
            end
            ST_D_HI: begin
                if (accept) begin
                    // idx_reg < n_reg <= 2**AW here, so the low AW bits never wrap.
                    we_next    = 1'b1;
                    addr_next  = idx_reg[AW-1:0];
                    wdata_next = {rx_data[3:0], lo_reg};
                    idx_next   = idx_inc;
                    state_next = (idx_inc == n_reg) ? ST_CSUM : ST_D_LO;
                end
            end
            ST_CSUM: begin
                if (accept) begin
                    if (sum_add == 8'h00) begin
                        state_next = ST_RUN;
                    end else begin
                        state_next    = ST_ERROR;
                        err_code_next = ERR_CSUM;
                    end
                end
            end
            ST_RUN: begin
            end
            default: begin
                state_next = ST_SYNC;
            end
        endcase

        // A byte arriving on the deadline cycle still counts as in time.
        if (framing && !accept && idle_reg == IDLE_LAST) begin
            state_next    = ST_ERROR;
            err_code_next = ERR_TIMEOUT;
            idle_next     = '0;
        end

        // Reload / abort wins over everything else; a write decided this cycle is dropped.
        if (boot_req && state_reg != ST_SYNC) begin
            state_next    = ST_SYNC;
            err_code_next = ERR_NONE;
            we_next       = 1'b0;
            idle_next     = '0;
        end
    end

    assign state    = state_reg;
    assign err_code = err_code_reg;
    assign wr_en    = we_reg;
    assign wr_addr  = addr_reg;
    assign wr_data  = wdata_reg;

endmodule

// File: rtl/ms_pic165x_boot_ctrl.sv
// Boot/load controller for the ms_pic165x core.
// Loads a framed program image from a UART byte stream into the instruction RAM,
// holds the core in reset until the checksum verifies, then hands the RAM read
// port to the core fetch path (zero-latency, RAM read is asynchronous).
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   rx_data/rx_valid/rx_ready   byte stream from the UART receiver
//   boot_req                    single-cycle reload request
//   pc/instr                    core fetch address and returned instruction
//   core_rst_n                  core reset, active-low
//   mem_addr/mem_wdata/mem_we/mem_rdata  instruction RAM port
//   busy/done/err/err_code      loader status
module ms_pic165x_boot_ctrl
    import ms_pic165x_pkg::*;
#(
    parameter int         AW          = 10,
    parameter logic [7:0] SYNC_BYTE   = 8'hA5,
    parameter int         TIMEOUT_CYC = 65535
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [7:0]    rx_data,
    input  logic          rx_valid,
    output logic          rx_ready,
    input  logic          boot_req,
    input  logic [AW-1:0] pc,
    output logic [11:0]   instr,
    output logic          core_rst_n,
    output logic [AW-1:0] mem_addr,
    output logic [11:0]   mem_wdata,
    output logic          mem_we,
    input  logic [11:0]   mem_rdata,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [1:0]    err_code
);

    boot_state_t   state;
    logic [1:0]    code;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [11:0]   wr_data;
    logic          run;

    ms_boot_frame_fsm #(
        .AW          (AW),
        .SYNC_BYTE   (SYNC_BYTE),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_frame_fsm (
        .clk      (clk),
        .rst      (rst),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .boot_req (boot_req),
        .state    (state),
        .err_code (code),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data)
    );

    assign run = (state == ST_RUN);

    // The core owns the RAM address only while running; otherwise the loader does.
    assign mem_addr   = run ? pc : wr_addr;
    assign instr      = run ? mem_rdata : NOP;
    assign mem_wdata  = wr_data;
    assign mem_we     = wr_en && !run;
    assign core_rst_n = run;
    assign done       = run;
    assign rx_ready   = !run;
    assign busy       = in_frame(state);
    assign err        = (state == ST_ERROR);
    assign err_code   = code;

endmodule

// File: tb/tb_ms_pic165x_boot_ctrl.sv
// Self-checking bench for ms_pic165x_boot_ctrl (AW=10, TIMEOUT_CYC=100).
// A frame-level model tracks the loader's observable mode from byte positions in
// the frame; a negedge process compares every output against it each cycle.
module tb_ms_pic165x_boot_ctrl;

    localparam int AW = 10;
    localparam int TO = 100;
    localparam int M_IDLE = 0, M_FRAME = 1, M_RUN = 2, M_ERR = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic [7:0]    rx_data;
    logic          rx_valid;
    logic          rx_ready;
    logic          boot_req;
    logic [AW-1:0] pc;
    logic [11:0]   instr;
    logic          core_rst_n;
    logic [AW-1:0] mem_addr;
    logic [11:0]   mem_wdata;
    logic          mem_we;
    logic [11:0]   mem_rdata;
    logic          busy, done, err;
    logic [1:0]    err_code;

    ms_pic165x_boot_ctrl #(.AW(AW), .SYNC_BYTE(8'hA5), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .boot_req(boot_req), .pc(pc), .instr(instr), .core_rst_n(core_rst_n),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata),
        .busy(busy), .done(done), .err(err), .err_code(err_code)
    );

    always #5 clk = ~clk;

    // Instruction RAM environment: synchronous write, asynchronous read.
    logic [11:0]   env_ram [0:1023] = '{default: 12'h000};
    logic [AW-1:0] last_wr_addr = '0;
    assign mem_rdata = env_ram[mem_addr];
    always @(posedge clk) begin
        if (mem_we) begin
            env_ram[mem_addr] <= mem_wdata;
            last_wr_addr      <= mem_addr;
        end
    end

    // Model state
    int            mode, code, idle, n;
    logic [7:0]    fb[$];
    logic [11:0]   img [0:1023] = '{default: 12'h000};
    bit            exp_we;
    logic [AW-1:0] exp_addr;
    logic [11:0]   exp_data;
    int            checks, errors;
    bit            chk_en;

    logic [11:0]   words[$];
    logic [7:0]    frame_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h at t=%0t", name, act, req, $time);
        end
    endtask

    task automatic model_byte(input logic [7:0] d);
        int s;
        logic [7:0] sum;
        if (mode == M_IDLE || mode == M_ERR) begin
            if (d == 8'hA5) begin
                mode = M_FRAME; fb.delete(); idle = 0; code = 0;
            end
        end else begin
            idle = 0;
            fb.push_back(d);
            s = fb.size();
            if (s == 2) begin
                n = {16'd0, fb[1], fb[0]};
                if (n == 0 || n > (1 << AW)) begin mode = M_ERR; code = 1; end
            end else if (s >= 3 && s <= 2 + 2 * n) begin
                if (s % 2 == 0) begin
                    exp_we   = 1'b1;
                    exp_addr = AW'((s - 4) / 2);
                    exp_data = {fb[s-1][3:0], fb[s-2]};
                    img[(s - 4) / 2] = exp_data;
                end
            end else if (s == 3 + 2 * n) begin
                sum = 8'h00;
                foreach (fb[i]) sum = sum + fb[i];
                if (sum == 8'h00) mode = M_RUN;
                else begin mode = M_ERR; code = 2; end
            end
        end
    endtask

    task automatic model_edge(input bit v, input logic [7:0] d, input bit br, input bit r);
        exp_we = 1'b0;
        if (r || br) begin
            mode = M_IDLE; code = 0; idle = 0;
        end else if (v && mode != M_RUN) begin
            model_byte(d);
        end else if (mode == M_FRAME) begin
            idle++;
            if (idle == TO) begin mode = M_ERR; code = 3; end
        end
    endtask

    // One clock: drive inputs, take the edge, advance the model.
    task automatic step(input bit v, input logic [7:0] d, input bit br, input bit r, input int p);
        rx_valid = v; rx_data = d; boot_req = br; rst = r;
        if (p < 0) pc = AW'($urandom_range(0, (1 << AW) - 1));
        else       pc = AW'(p);
        @(posedge clk);
        #1;
        rx_valid = 1'b0; boot_req = 1'b0; rst = 1'b0;
        model_edge(v, d, br, r);
    endtask

    task automatic idle_cycles(input int k);
        for (int i = 0; i < k; i++) step(1'b0, 8'h00, 1'b0, 1'b0, -1);
    endtask

    task automatic build_frame(input logic [15:0] cnt, input logic [7:0] csum_delta, input logic [3:0] hi_junk);
        logic [7:0] s;
        frame_q.delete();
        frame_q.push_back(8'hA5);
        frame_q.push_back(cnt[7:0]);
        frame_q.push_back(cnt[15:8]);
        foreach (words[i]) begin
            frame_q.push_back(words[i][7:0]);
            frame_q.push_back({hi_junk, words[i][11:8]});
        end
        s = 8'h00;
        for (int i = 1; i < frame_q.size(); i++) s = s + frame_q[i];
        frame_q.push_back(8'h00 - s + csum_delta);
    endtask

    task automatic send_frame(input string tag);
        foreach (frame_q[i]) step(1'b1, frame_q[i], 1'b0, 1'b0, -1);
        $display("txn %s: %0d bytes, done=%0b err=%0b err_code=%0d", tag, frame_q.size(), done, err, err_code);
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("rx_ready",   32'(rx_ready),   32'(mode != M_RUN));
            chk("core_rst_n", 32'(core_rst_n), 32'(mode == M_RUN));
            chk("done",       32'(done),       32'(mode == M_RUN));
            chk("busy",       32'(busy),       32'(mode == M_FRAME));
            chk("err",        32'(err),        32'(mode == M_ERR));
            chk("err_code",   32'(err_code),   32'(code));
            chk("mem_we",     32'(mem_we),     32'(exp_we));
            if (exp_we) begin
                chk("wr_addr", 32'(mem_addr),  32'(exp_addr));
                chk("wr_data", 32'(mem_wdata), 32'(exp_data));
            end
            if (mode == M_RUN) chk("fetch_addr", 32'(mem_addr), 32'(pc));
            chk("instr", 32'(instr), 32'((mode == M_RUN) ? img[pc] : 12'h000));
        end
    end

    initial begin
        rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; boot_req = 1'b0; pc = '0;
        checks = 0; errors = 0; chk_en = 1'b0;
        mode = M_IDLE; code = 0; idle = 0; n = 0; exp_we = 1'b0; exp_addr = '0; exp_data = '0;

        step(1'b0, 8'h00, 1'b0, 1'b1, 0);
        step(1'b0, 8'h00, 1'b0, 1'b1, 0);
        chk_en = 1'b1;
        chk("reset_core_rst_n", 32'(core_rst_n), 32'd0);
        chk("reset_rx_ready",   32'(rx_ready),   32'd1);
        chk("reset_instr",      32'(instr),      32'h000);
        chk("reset_mem_we",     32'(mem_we),     32'd0);
        chk("reset_err_code",   32'(err_code),   32'd0);

        // Garbage, then the valid image.
        step(1'b1, 8'h00, 1'b0, 1'b0, -1);
        step(1'b1, 8'hFF, 1'b0, 1'b0, -1);
        step(1'b1, 8'h5A, 1'b0, 1'b0, -1);
        words = '{12'hC01, 12'h025, 12'hA00};
        build_frame(16'd3, 8'h00, 4'h0);
        chk("frame1_csum_byte", 32'(frame_q[9]), 32'h0000_00C1);
        send_frame("valid image after garbage");
        idle_cycles(2);
        chk("ram0", 32'(env_ram[0]), 32'h0C01);
        chk("ram1", 32'(env_ram[1]), 32'h0025);
        chk("ram2", 32'(env_ram[2]), 32'h0A00);
        chk("run_done", 32'(done), 32'd1);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1);
        chk("run_instr_pc1", 32'(instr), 32'h025);
        step(1'b1, 8'hA5, 1'b0, 1'b0, 2);
        chk("run_instr_pc2", 32'(instr), 32'hA00);

        step(1'b0, 8'h00, 1'b1, 1'b0, -1);
        chk("reload_core_rst_n", 32'(core_rst_n), 32'd0);
        chk("reload_done", 32'(done), 32'd0);

        build_frame(16'd3, 8'h01, 4'h0);
        send_frame("bad checksum");
        idle_cycles(1);
        chk("csum_err", 32'(err), 32'd1);
        chk("csum_code", 32'(err_code), 32'd2);
        chk("csum_instr", 32'(instr), 32'h000);

        build_frame(16'd3, 8'h00, 4'h0);
        send_frame("restart from error");
        idle_cycles(1);
        chk("restart_done", 32'(done), 32'd1);
        step(1'b0, 8'h00, 1'b1, 1'b0, -1);

        step(1'b1, 8'hA5, 1'b0, 1'b0, -1);
        step(1'b1, 8'h00, 1'b0, 1'b0, -1);
        step(1'b1, 8'h00, 1'b0, 1'b0, -1);
        $display("txn count N=0: err=%0b err_code=%0d", err, err_code);
        chk("n0_code", 32'(err_code), 32'd1);
        step(1'b0, 8'h00, 1'b1, 1'b0, -1);
        chk("bootreq_clears_err", 32'(err), 32'd0);

        step(1'b1, 8'hA5, 1'b0, 1'b0, -1);
        step(1'b1, 8'h01, 1'b0, 1'b0, -1);
        step(1'b1, 8'h04, 1'b0, 1'b0, -1);
        $display("txn count N=1025: err=%0b err_code=%0d", err, err_code);
        chk("n1025_code", 32'(err_code), 32'd1);
        step(1'b0, 8'h00, 1'b1, 1'b0, -1);

        words.delete();
        for (int k = 0; k < 1024; k++) words.push_back(12'(k) ^ 12'h800);
        build_frame(16'd1024, 8'h00, 4'h0);
        send_frame("full image N=1024");
        idle_cycles(2);
        chk("n1024_last_addr", 32'(last_wr_addr), 32'd1023);
        chk("n1024_done", 32'(done), 32'd1);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1023);
        chk("n1024_instr_top", 32'(instr), 32'hBFF);
        step(1'b0, 8'h00, 1'b1, 1'b0, -1);

        // Stall in D_HI: error exactly TO cycles after the D_LO byte.
        step(1'b1, 8'hA5, 1'b0, 1'b0, -1);
        step(1'b1, 8'h03, 1'b0, 1'b0, -1);
        step(1'b1, 8'h00, 1'b0, 1'b0, -1);
        step(1'b1, 8'h01, 1'b0, 1'b0, -1);
        idle_cycles(TO - 1);
        chk("timeout_early_err", 32'(err), 32'd0);
        idle_cycles(1);
        $display("txn timeout stall: err=%0b err_code=%0d", err, err_code);
        chk("timeout_err", 32'(err), 32'd1);
        chk("timeout_code", 32'(err_code), 32'd3);
        step(1'b0, 8'h00, 1'b1, 1'b0, -1);

        words = '{12'h123, 12'h7FF};
        build_frame(16'd2, 8'h00, 4'hF);
        send_frame("reload image");
        idle_cycles(1);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1);
        chk("reload_instr_pc1", 32'(instr), 32'h7FF);
        step(1'b0, 8'h00, 1'b0, 1'b0, 0);
        chk("reload_instr_pc0", 32'(instr), 32'h123);

        // Reset on the cycle a HI byte is accepted: no write may follow.
        step(1'b0, 8'h00, 1'b1, 1'b0, -1);
        step(1'b1, 8'hA5, 1'b0, 1'b0, -1);
        step(1'b1, 8'h01, 1'b0, 1'b0, -1);
        step(1'b1, 8'h00, 1'b0, 1'b0, -1);
        step(1'b1, 8'h11, 1'b0, 1'b0, -1);
        step(1'b1, 8'h02, 1'b0, 1'b1, -1);
        $display("txn reset mid-D_HI: mem_we=%0b busy=%0b", mem_we, busy);
        chk("rst_mid_we", 32'(mem_we), 32'd0);
        chk("rst_mid_busy", 32'(busy), 32'd0);
        chk("rst_mid_rx_ready", 32'(rx_ready), 32'd1);
        idle_cycles(1);
        chk("rst_mid_ram0", 32'(env_ram[0]), 32'h123);
        idle_cycles(3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
